axi_burst_writer: RTL and testbench
===================================

// Module: axi_burst_writer
// PURPOSE
//  Synthesizable AXI4 write initiator: takes a (start address, word count) command plus a
//  data stream and writes it to memory as INCR bursts on the AW/W/B channels.
//  Sits between engine result/stream logic and the memory AXI port; the sim memory model
//  responds on the other side.
// PARAMETERS
//  ADDR_WIDTH       32              AXI address width
//  DATA_WIDTH       256             AXI/stream data width (power of 2, >=8)
//  STRB_WIDTH       DATA_WIDTH/8    bytes per beat
//  MAX_BURST_LEN    16              max beats per burst (1..256)
//  MAX_OUTSTANDING  4               max bursts issued on AW but not yet B-acknowledged
//  COUNT_WIDTH      24              width of command word count
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous reset, active-high
//  cmd_addr     in   ADDR_WIDTH   start byte address; low log2(STRB_WIDTH) bits ignored
//  cmd_words    in   COUNT_WIDTH  number of DATA_WIDTH beats to write
//  cmd_valid    in   1            command valid
//  cmd_ready    out  1            command accepted when valid&ready
//  s_data       in   DATA_WIDTH   stream data
//  s_valid      in   1            stream valid
//  s_ready      out  1            stream ready
//  busy         out  1            high from command accept until done
//  done         out  1            1-cycle pulse: all beats written and all B received
//  error        out  1            any B response != OKAY during current command
//  axi_aw*      out  -            awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid; in awready
//  axi_w*       out  -            wdata/wstrb/wlast/wvalid; in wready
//  axi_b*       in   -            bvalid, bresp[1:0]; out bready
// BEHAVIOUR
//  - Reset: state IDLE, cmd_ready=1, s_ready=0, awvalid=0, wvalid=0, bready=1, busy=0,
//    done=0, error=0, outstanding counter=0. Reset mid-command aborts immediately; AXI
//    legality of the aborted transaction is not guaranteed (slave is reset together).
//  - States: IDLE -> ADDR -> DATA -> (ADDR | DRAIN) ; DRAIN -> DONE -> IDLE.
//  - IDLE: cmd_ready=1. Accept latches addr (aligned down to STRB_WIDTH), remaining=cmd_words,
//    clears error, busy=1. cmd_words==0 -> DONE directly (done high the next cycle, no AXI).
//  - ADDR: awvalid registered, asserted the cycle after entry when outstanding<MAX_OUTSTANDING;
//    held stable until awready. awsize=log2(STRB_WIDTH), awburst=2'b01 (INCR).
//    beats = min(remaining, MAX_BURST_LEN, beats-to-4KB-boundary [see CONFIGURATION]);
//    awlen=beats-1. AW handshake: outstanding++, goes to DATA.
//  - DATA: wvalid=s_valid, s_ready=wready, wdata=s_data, wstrb all ones (combinational pass,
//    beats only counted on wvalid&wready). wlast=1 on beat awlen. After last-beat handshake:
//    addr+=beats*STRB_WIDTH, remaining-=beats; remaining>0 -> ADDR, else DRAIN.
//  - s_ready=0 and wvalid=0 in every state other than DATA.
//  - B channel: bready=1 always; each bvalid: outstanding--; bresp!=2'b00 sets error (sticky
//    until next accept). Simultaneous AW handshake and B: counter unchanged.
//  - DRAIN: wait outstanding==0 (counter include same-cycle B). DONE: done=1 one cycle,
//    busy falls same cycle as done, IDLE next.
//  - Address wraps modulo 2^ADDR_WIDTH; no range check.
// CONFIGURATION
//  AXI_BURST_WRITER_4K_SPLIT_EN
//   defined: burst length additionally clipped so no burst crosses a 4 KB address boundary
//     (AXI4 compliant).
//   undefined: only MAX_BURST_LEN / remaining limit burst length; 4 KB crossings allowed
//     (smaller logic; only for slaves that tolerate it, e.g. sim memory model).
// TESTING (DATA_WIDTH=256, STRB_WIDTH=32, MAX_BURST_LEN=16)
//  1 addr=0x1000, words=40 -> AW 0x1000 len15, 0x1200 len15, 0x1400 len7; 40 beats in order,
//    3 wlast; done once after 3rd B; memory readback matches stream.
//  2 addr=0x0FC0, words=8, 4K_SPLIT_EN defined -> AW 0x0FC0 len1, 0x1000 len5;
//    undefined -> single AW 0x0FC0 len7.
//  3 words=0 -> done pulse the cycle after accept, awvalid never asserted, busy 1 cycle.
//  4 random wready/awready stalls + s_valid gaps, words=100 -> awaddr/awlen stable while
//    stalled, no beat lost/duplicated, wlast exactly on beat awlen of each burst.
//  5 MAX_OUTSTANDING=4, bvalid held low, words=128 -> exactly 4 AW issued then awvalid low;
//    releasing one B allows 5th AW; second burst bresp=2'b10 -> error=1 at done, cleared on
//    next accept.
//  6 rst asserted mid-DATA -> next cycle awvalid=wvalid=s_ready=0, cmd_ready=1, busy=0;
//    following command words=16 completes normally.

Source files
------------

// File: rtl/axi_burst_writer.sv
// AXI4 write initiator: splits a (start address, word count) command plus a data stream into INCR bursts.
// Optional macro AXI_BURST_WRITER_4K_SPLIT_EN clips bursts so none crosses a 4 KB address boundary.
module axi_burst_writer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [COUNT_WIDTH-1:0] cmd_words,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH-1:0]  axi_awaddr,
  output logic [7:0]             axi_awlen,
  output logic [2:0]             axi_awsize,
  output logic [1:0]             axi_awburst,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [DATA_WIDTH-1:0]  axi_wdata,
  output logic [STRB_WIDTH-1:0]  axi_wstrb,
  output logic                   axi_wlast,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  input  logic                   axi_bvalid,
  input  logic [1:0]             axi_bresp,
  output logic                   axi_bready
);

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [8:0]             beats_q, beats_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic                   awvalid_q, awvalid_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic                   error_q, error_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;

  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0]  a,
                                             input logic [COUNT_WIDTH-1:0] rem);
    logic [8:0] b;
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    logic [12:0] to_4k;
`endif
    if (rem < COUNT_WIDTH'(MAX_BURST_LEN)) b = 9'(rem);
    else                                   b = 9'(MAX_BURST_LEN);
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    // addr is beat aligned, so the byte distance divides exactly into beats
    to_4k = (13'd4096 - {1'b0, a[11:0]}) >> SIZE_LOG2;
    if (to_4k < {4'd0, b}) b = to_4k[8:0];
`else
    if (a == '0) b = b;
`endif
    return b;
  endfunction

  assign aw_hs     = awvalid_q && axi_awready;
  assign w_hs      = axi_wvalid && axi_wready;
  assign b_hs      = axi_bvalid;
  assign last_beat = (beat_cnt_q == beats_q - 9'd1);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    beats_d       = beats_q;
    beat_cnt_d    = beat_cnt_q;
    awvalid_d     = awvalid_q;
    error_d       = error_q;
    outstanding_d = outstanding_q;

    // a same-cycle AW issue and B return cancel out
    if (aw_hs && !b_hs) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!aw_hs && b_hs && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end
    if (b_hs && (axi_bresp != 2'b00)) error_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ALIGN_MASK;
          remaining_d = cmd_words;
          error_d     = 1'b0;
          beat_cnt_d  = '0;
          state_d     = (cmd_words == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (!awvalid_q) begin
          if (outstanding_q < OUT_W'(MAX_OUTSTANDING)) begin
            awvalid_d = 1'b1;
            beats_d   = burst_beats(addr_q, remaining_q);
          end
        end else if (axi_awready) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (last_beat) begin
            addr_d      = addr_q + (ADDR_WIDTH'(beats_q) << SIZE_LOG2);
            remaining_d = remaining_q - COUNT_WIDTH'(beats_q);
            beat_cnt_d  = '0;
            state_d     = (remaining_q == COUNT_WIDTH'(beats_q)) ? S_DRAIN : S_ADDR;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      S_DRAIN: begin
        if (outstanding_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // control state: reset applies here only
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      awvalid_q     <= 1'b0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  // address/length datapath: always rewritten before use
  always_ff @(posedge clk) begin
    addr_q      <= addr_d;
    remaining_q <= remaining_d;
    beats_q     <= beats_d;
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign s_ready     = (state_q == S_DATA) && axi_wready;
  assign axi_wvalid  = (state_q == S_DATA) && s_valid;
  assign axi_wdata   = s_data;
  assign axi_wstrb   = '1;
  assign axi_wlast   = (state_q == S_DATA) && last_beat;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'(beats_q - 9'd1);
  assign axi_awsize  = 3'(SIZE_LOG2);
  assign axi_awburst = 2'b01;
  assign axi_awvalid = awvalid_q;
  assign axi_bready  = 1'b1;
  // busy spans the done cycle and drops together with done
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = error_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer with a behavioural AXI slave, memory and stream source.
// Expected burst layout follows AXI_BURST_WRITER_4K_SPLIT_EN when it is defined for the build.
module tb_axi_burst_writer;

  logic         clk;
  logic         rst;
  logic [31:0]  cmd_addr;
  logic [23:0]  cmd_words;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         busy;
  logic         done;
  logic         error;
  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic         axi_bvalid;
  logic [1:0]   axi_bresp;
  logic         axi_bready;

  axi_burst_writer dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_words(cmd_words), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .error(error),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // slave / source state
  logic [255:0] mem [logic [31:0]];
  logic [31:0]  awq_addr[$];
  logic [7:0]   awq_len[$];
  logic [255:0] sq[$];
  logic [1:0]   bq[$];
  logic [31:0]  awl_addr[$];
  logic [7:0]   awl_len[$];
  int aw_cnt = 0, beat_cnt = 0, wlast_cnt = 0, b_cnt = 0, done_cnt = 0, busy_cycles = 0;
  int b_at_done = 0, proto_err = 0, w_burst_idx = 0, wcnt = 0;
  int err_burst = -1, b_allow = -1;
  bit aw_stall = 0, w_stall = 0, s_gaps = 0;
  bit aw_prev_stall = 0;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [15:0] tag, input int i);
    return {8{tag, 16'(i)}};
  endfunction

  function automatic logic [39:0] aw_at(input int idx);
    if (idx < awl_addr.size()) return {awl_addr[idx], awl_len[idx]};
    return 40'hdead_dead_ff;
  endfunction

  // slave and stream source: drive on negedge, observe handshakes just before posedge
  always begin
    logic [31:0] widx;
    @(negedge clk);
    axi_awready = aw_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    axi_wready  = w_stall  ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_valid     = (sq.size() > 0) && (s_gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
    s_data      = (sq.size() > 0) ? sq[0] : '0;
    axi_bvalid  = (bq.size() > 0) && (b_allow != 0);
    axi_bresp   = (bq.size() > 0) ? bq[0] : 2'b00;
    #3;
    if (rst) begin
      awq_addr.delete(); awq_len.delete(); sq.delete(); bq.delete();
      wcnt = 0; aw_prev_stall = 0;
    end else begin
      if (axi_awvalid && (axi_awsize != 3'd5 || axi_awburst != 2'b01)) proto_err++;
      if (aw_prev_stall && (!axi_awvalid || axi_awaddr != prev_awaddr || axi_awlen != prev_awlen))
        proto_err++;
      aw_prev_stall = axi_awvalid && !axi_awready;
      prev_awaddr = axi_awaddr;
      prev_awlen  = axi_awlen;
      if (axi_awvalid && axi_awready) begin
        awq_addr.push_back(axi_awaddr); awq_len.push_back(axi_awlen);
        awl_addr.push_back(axi_awaddr); awl_len.push_back(axi_awlen);
        aw_cnt++;
      end
      if ((s_valid && s_ready) != (axi_wvalid && axi_wready)) proto_err++;
      if (axi_wvalid && axi_wready) begin
        if (axi_wstrb != '1) proto_err++;
        if (awq_addr.size() == 0 || sq.size() == 0) begin
          proto_err++;
        end else begin
          if (axi_wdata != sq[0]) proto_err++;
          void'(sq.pop_front());
          widx = (awq_addr[0] >> 5) + 32'(wcnt);
          mem[widx] = axi_wdata;
          if (axi_wlast != (wcnt == int'(awq_len[0]))) proto_err++;
          if (wcnt == int'(awq_len[0])) begin
            void'(awq_addr.pop_front()); void'(awq_len.pop_front());
            bq.push_back((w_burst_idx == err_burst) ? 2'b10 : 2'b00);
            w_burst_idx++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
        if (axi_wlast) wlast_cnt++;
        beat_cnt++;
      end
      if (axi_bvalid && axi_bready) begin
        void'(bq.pop_front());
        b_cnt++;
        if (b_allow > 0) b_allow--;
      end
      if (done) begin
        done_cnt++;
        b_at_done = b_cnt;
      end
      if (busy) busy_cycles++;
    end
  end

  task automatic load_stream(input logic [15:0] tag, input int words);
    for (int i = 0; i < words; i++) sq.push_back(pat(tag, i));
  endtask

  task automatic send_cmd(input logic [31:0] a, input int w);
    int k;
    @(negedge clk);
    cmd_addr = a; cmd_words = 24'(w); cmd_valid = 1'b1;
    k = 0;
    #4;
    while (!cmd_ready && k < 100) begin
      @(negedge clk); #4; k++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge clk); k++;
    end
    chk(tag, 64'(done_cnt > base), 64'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic [15:0] ctag,
                           input int words);
    int mism;
    logic [31:0] idx;
    mism = 0;
    for (int i = 0; i < words; i++) begin
      idx = (a >> 5) + 32'(i);
      if (!mem.exists(idx)) mism++;
      else if (mem[idx] != pat(ctag, i)) mism++;
    end
    chk(tag, 64'(mism), 64'd0);
  endtask

  initial begin
    int aw0, bt0, wl0, dn0, pe0, b0, bz0, k;
    rst = 1'b1; cmd_addr = '0; cmd_words = '0; cmd_valid = 1'b0;
    s_valid = 1'b0; s_data = '0; axi_awready = 1'b1; axi_wready = 1'b1;
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rst_bready", 64'(axi_bready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    rst = 1'b0;

    // 1: three bursts of 16/16/8
    aw0 = aw_cnt; bt0 = beat_cnt; wl0 = wlast_cnt; dn0 = done_cnt; pe0 = proto_err; b0 = b_cnt;
    load_stream(16'h0001, 40);
    send_cmd(32'h1000, 40);
    wait_done(dn0, 400, "t1_done_seen");
    chk("t1_aw_count", 64'(aw_cnt - aw0), 64'd3);
    chk("t1_aw0", 64'(aw_at(aw0)), {24'd0, 32'h1000, 8'd15});
    chk("t1_aw1", 64'(aw_at(aw0 + 1)), {24'd0, 32'h1200, 8'd15});
    chk("t1_aw2", 64'(aw_at(aw0 + 2)), {24'd0, 32'h1400, 8'd7});
    chk("t1_beats", 64'(beat_cnt - bt0), 64'd40);
    chk("t1_wlast", 64'(wlast_cnt - wl0), 64'd3);
    chk("t1_done_once", 64'(done_cnt - dn0), 64'd1);
    chk("t1_b_at_done", 64'(b_at_done - b0), 64'd3);
    chk("t1_proto", 64'(proto_err - pe0), 64'd0);
    check_mem("t1_mem", 32'h1000, 16'h0001, 40);

    // 2: start 64 bytes below a 4 KB boundary
    aw0 = aw_cnt; dn0 = done_cnt; pe0 = proto_err;
    load_stream(16'h0002, 8);
    send_cmd(32'h0FC0, 8);
    wait_done(dn0, 200, "t2_done_seen");
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    chk("t2_aw_count", 64'(aw_cnt - aw0), 64'd2);
    chk("t2_aw0", 64'(aw_at(aw0)), {24'd0, 32'h0FC0, 8'd1});
    chk("t2_aw1", 64'(aw_at(aw0 + 1)), {24'd0, 32'h1000, 8'd5});
`else
    chk("t2_aw_count", 64'(aw_cnt - aw0), 64'd1);
    chk("t2_aw0", 64'(aw_at(aw0)), {24'd0, 32'h0FC0, 8'd7});
`endif
    chk("t2_proto", 64'(proto_err - pe0), 64'd0);
    check_mem("t2_mem", 32'h0FC0, 16'h0002, 8);

    // 3: zero-length command
    aw0 = aw_cnt; bt0 = beat_cnt; bz0 = busy_cycles;
    send_cmd(32'h3000, 0);
    #4;
    chk("t3_done_next", 64'(done), 64'd1);
    chk("t3_busy_next", 64'(busy), 64'd1);
    @(negedge clk); #4;
    chk("t3_done_after", 64'(done), 64'd0);
    chk("t3_busy_after", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_busy_cycles", 64'(busy_cycles - bz0), 64'd1);
    chk("t3_no_aw", 64'(aw_cnt - aw0), 64'd0);
    chk("t3_no_beats", 64'(beat_cnt - bt0), 64'd0);

    // 4: random back-pressure and stream gaps
    aw0 = aw_cnt; bt0 = beat_cnt; wl0 = wlast_cnt; dn0 = done_cnt; pe0 = proto_err;
    aw_stall = 1; w_stall = 1; s_gaps = 1;
    load_stream(16'h0004, 100);
    send_cmd(32'h2000, 100);
    wait_done(dn0, 3000, "t4_done_seen");
    aw_stall = 0; w_stall = 0; s_gaps = 0;
    chk("t4_aw_count", 64'(aw_cnt - aw0), 64'd7);
    chk("t4_aw_last", 64'(aw_at(aw0 + 6)), {24'd0, 32'h2C00, 8'd3});
    chk("t4_beats", 64'(beat_cnt - bt0), 64'd100);
    chk("t4_wlast", 64'(wlast_cnt - wl0), 64'd7);
    chk("t4_proto", 64'(proto_err - pe0), 64'd0);
    check_mem("t4_mem", 32'h2000, 16'h0004, 100);

    // 5: outstanding limit with B held, second burst answered SLVERR
    aw0 = aw_cnt; dn0 = done_cnt; pe0 = proto_err;
    err_burst = w_burst_idx + 1; b_allow = 0;
    load_stream(16'h0005, 128);
    send_cmd(32'h4000, 128);
    repeat (150) @(negedge clk);
    #4;
    chk("t5_aw_held", 64'(aw_cnt - aw0), 64'd4);
    chk("t5_awvalid_low", 64'(axi_awvalid), 64'd0);
    @(negedge clk);
    b_allow = 1;
    repeat (30) @(negedge clk);
    #4;
    chk("t5_aw_fifth", 64'(aw_cnt - aw0), 64'd5);
    @(negedge clk);
    b_allow = -1;
    wait_done(dn0, 1000, "t5_done_seen");
    err_burst = -1;
    chk("t5_error", 64'(error), 64'd1);
    chk("t5_proto", 64'(proto_err - pe0), 64'd0);
    check_mem("t5_mem", 32'h4000, 16'h0005, 128);

    // error clears on next accept
    dn0 = done_cnt;
    load_stream(16'h0055, 16);
    send_cmd(32'h8000, 16);
    #4;
    chk("t5_error_cleared", 64'(error), 64'd0);
    wait_done(dn0, 200, "t5b_done_seen");
    chk("t5b_error_end", 64'(error), 64'd0);

    // 6: reset mid-DATA, then a clean command
    load_stream(16'h0006, 64);
    send_cmd(32'hA000, 64);
    k = 0;
    #4;
    while (!axi_wvalid && k < 100) begin
      @(negedge clk); #4; k++;
    end
    chk("t6_in_data", 64'(axi_wvalid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_awvalid", 64'(axi_awvalid), 64'd0);
    chk("t6_wvalid", 64'(axi_wvalid), 64'd0);
    chk("t6_s_ready", 64'(s_ready), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    aw0 = aw_cnt; bt0 = beat_cnt; dn0 = done_cnt; pe0 = proto_err;
    load_stream(16'h0066, 16);
    send_cmd(32'hB000, 16);
    wait_done(dn0, 200, "t6_done_seen");
    chk("t6_aw", 64'(aw_at(aw0)), {24'd0, 32'hB000, 8'd15});
    chk("t6_beats", 64'(beat_cnt - bt0), 64'd16);
    chk("t6_proto", 64'(proto_err - pe0), 64'd0);
    check_mem("t6_mem", 32'hB000, 16'h0066, 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
